chunked_serial_adder: RTL
=========================

Name: chunked_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. Successor to the 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, LSB chunk first, through a registered carry. It trades latency for area in wide datapaths and exposes a start/busy/done handshake to the controlling FSM.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH. N = WIDTH/CHUNK is the number of processing cycles.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; accepted only when not busy
sub  in  1  0 = add, 1 = subtract (a - b); sampled with start
a  in  WIDTH  operand A, sampled on accepted start
b  in  WIDTH  operand B, sampled on accepted start
cin  in  1  carry-in (add) / borrow-in (sub), sampled on accepted start
busy  out  1  high while chunks are being processed
done  out  1  one-cycle pulse when result is valid
sum  out  WIDTH  result, held stable from done until the next accepted start
cout  out  1  carry-out (add); in sub mode 1 = no borrow, 0 = borrow
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, chunk counter=0, internal operand/carry registers=0. Reset overrides start and aborts any operation in progress; no done is produced for the aborted operation.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN
  - RUN --(last chunk)--> DONE
  - DONE --start--> RUN
  - DONE --no start--> IDLE
- Accept rule: start is accepted on an edge when state is IDLE or DONE.
  - On the accepted edge, latch a, b_eff and carry_eff; clear the counter; busy=1 from the next cycle.
  - start while in RUN is ignored and has no side effects.
  - Operand changes while busy have no effect.
- Operand conditioning:
  - Add: b_eff = b, carry_eff = cin.
  - Sub: b_eff = ~b, carry_eff = ~cin, so cin acts as borrow-in and the result is a - b - cin.
- RUN: each edge adds chunk k of a and b_eff plus the carry register, stores the CHUNK-bit partial result into sum bits [k*CHUNK +: CHUNK], updates the carry register, and increments k.
  - Exactly N RUN edges occur.
  - Edge N also captures cout = final carry and ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- Latency: with the start accepted at edge t0, done=1 and busy=0 during the cycle after edge t0+N. done is high for exactly one cycle. busy is high for exactly N cycles.
- Back-to-back: start asserted during the done cycle is accepted; busy rises the next cycle with no idle bubble.
- sum is internal working storage during RUN and is only guaranteed valid from done onward. Between done and the next accepted start, sum/cout/ovf hold.
- N=1 (CHUNK=WIDTH): a single RUN cycle; behaves as a registered adder with 2-cycle start-to-done.
- Counter width is clog2(N), minimum 1 bit; wrap is unreachable because the counter is cleared on accept.

Decomposition:
- Shared package adder_pkg holds the state typedef (IDLE, RUN, DONE) and the ADD/SUB mode constants.
- Sub-module chunk_adder: combinational CHUNK-bit ripple adder.
  - Inputs: x, y, ci.
  - Outputs: s, co, and c_msb (carry into its top bit, used for ovf).
- chunked_serial_adder instantiates one chunk_adder and owns the FSM, counter and registers.

Test Plan:
- WIDTH=16, CHUNK=4, add 0x1234 + 0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; done exactly 5 cycles after the start cycle; busy high 4 cycles.
- Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Issue the second start during the first done cycle to check back-to-back acceptance.
- Sub 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Sub 0x8000 - 0x0001, cin=1 -> sum=0x7FFE, cout=1, ovf=1.
- Pulse start mid-RUN with different operands -> ignored; original result and timing unchanged. Assert rst on the 2nd RUN cycle -> next cycle busy=0, sum=0, cout=0, ovf=0, no done pulse.
- WIDTH=8, CHUNK=8, add 0x80 + 0x80, cin=0 -> sum=0x00, cout=1, ovf=1, done 2 cycles after the start cycle.
- WIDTH=8, CHUNK=1, add 0x55 + 0xAA, cin=1 -> sum=0x00, cout=1, ovf=0, busy high 8 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared FSM state and operation-mode encodings for the chunked serial adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; c_msb is the carry into the top bit (for overflow).
// Zero latency, no flow control.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/sub, CHUNK bits per clock LSB first; done pulses N+1 cycles after start.
// start is ignored while busy; results hold until the next accepted start.
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last;
   logic [CHUNK-1:0] part_s;
   logic             part_co;
   logic             part_cmsb;

   assign last = (cnt == CW'(N - 1));
   assign busy = (state == RUN);
   assign done = (state == DONE);

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .x     (a_q[cnt*CHUNK +: CHUNK]),
      .y     (b_q[cnt*CHUNK +: CHUNK]),
      .ci    (carry_q),
      .s     (part_s),
      .co    (part_co),
      .c_msb (part_cmsb)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               accept    = 1'b1;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            accept    = start;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            // subtraction is a + ~b + ~borrow, so cin doubles as borrow-in
            a_q     <= a;
            b_q     <= (sub == MODE_SUB) ? ~b : b;
            carry_q <= (sub == MODE_SUB) ? ~cin : cin;
            cnt     <= '0;
         end else if (state == RUN) begin
            sum[cnt*CHUNK +: CHUNK] <= part_s;
            carry_q                 <= part_co;
            cnt                     <= cnt + 1'b1;
            if (last) begin
               cout <= part_co;
               ovf  <= part_co ^ part_cmsb;
            end
         end
      end
   end

endmodule
